// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone B4 classic arbiter: round-robin grant,
// bus lock for a whole CYC, and a watchdog that terminates hung cycles with ERR.
module wb_arbiter_2m #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2*AW-1:0]     m_adr_i,
    input  logic [2*DW-1:0]     m_dat_i,
    input  logic [2*(DW/8)-1:0] m_sel_i,
    input  logic [1:0]          m_we_i,
    input  logic [1:0]          m_cyc_i,
    input  logic [1:0]          m_stb_i,
    output logic [DW-1:0]       m_dat_o,
    output logic [1:0]          m_ack_o,
    output logic [1:0]          m_err_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    localparam int unsigned SW    = DW / 8;
    localparam int unsigned WDW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           last_grant, last_grant_nxt;
    logic [WDW-1:0] wd_cnt, wd_cnt_nxt;
    logic           granted_stb;
    logic           wd_expire;

    // State, round-robin pointer and watchdog registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wd_cnt     <= wd_cnt_nxt;
        end
    end

    // Next grant: the current owner keeps the bus until it drops CYC
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        unique case (state)
            IDLE: begin
                unique case (m_cyc_i)
                    2'b01:   state_nxt = GNT0;
                    2'b10:   state_nxt = GNT1;
                    2'b11:   state_nxt = last_grant ? GNT0 : GNT1;
                    default: state_nxt = IDLE;
                endcase
            end
            GNT0: begin
                if (!m_cyc_i[0]) begin
                    last_grant_nxt = 1'b0;
                    state_nxt      = m_cyc_i[1] ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m_cyc_i[1]) begin
                    last_grant_nxt = 1'b1;
                    state_nxt      = m_cyc_i[0] ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_o = {state == GNT1, state == GNT0};

    // Slave-side mux of the granted master; everything parked at 0 when idle
    always_comb begin
        s_adr_o     = '0;
        s_dat_o     = '0;
        s_sel_o     = '0;
        s_we_o      = 1'b0;
        s_cyc_o     = 1'b0;
        granted_stb = 1'b0;
        unique case (state)
            GNT0: begin
                s_adr_o     = m_adr_i[0 +: AW];
                s_dat_o     = m_dat_i[0 +: DW];
                s_sel_o     = m_sel_i[0 +: SW];
                s_we_o      = m_we_i[0];
                s_cyc_o     = m_cyc_i[0];
                granted_stb = m_stb_i[0];
            end
            GNT1: begin
                s_adr_o     = m_adr_i[AW +: AW];
                s_dat_o     = m_dat_i[DW +: DW];
                s_sel_o     = m_sel_i[SW +: SW];
                s_we_o      = m_we_i[1];
                s_cyc_o     = m_cyc_i[1];
                granted_stb = m_stb_i[1];
            end
            default: ;
        endcase
    end

    // A same-cycle ack or err always beats the watchdog
    assign wd_expire = WD_EN && granted_stb && !s_ack_i && !s_err_i
                       && (wd_cnt == WDW'(TIMEOUT));

    always_comb begin
        wd_cnt_nxt = '0;
        if (WD_EN && (state_nxt == state) && granted_stb
            && !s_ack_i && !s_err_i && !wd_expire) begin
            wd_cnt_nxt = wd_cnt + WDW'(1);
        end
    end

    assign s_stb_o   = granted_stb & ~wd_expire;
    assign timeout_o = wd_expire;
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = {2{s_ack_i}} & m_stb_i & grant_o;
    assign m_err_o   = {2{s_err_i | wd_expire}} & m_stb_i & grant_o;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: grant order, bus lock, watchdog and reset.
module tb_wb_arbiter_2m;

    logic        clk;
    logic        reset_n;
    logic [63:0] m_adr_i;
    logic [63:0] m_dat_i;
    logic [7:0]  m_sel_i;
    logic [1:0]  m_we_i;
    logic [1:0]  m_cyc_i;
    logic [1:0]  m_stb_i;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_err_i;

    logic [31:0] m_dat_o,  m_dat_o_z;
    logic [1:0]  m_ack_o,  m_ack_o_z;
    logic [1:0]  m_err_o,  m_err_o_z;
    logic [31:0] s_adr_o,  s_adr_o_z;
    logic [31:0] s_dat_o,  s_dat_o_z;
    logic [3:0]  s_sel_o,  s_sel_o_z;
    logic        s_we_o,   s_we_o_z;
    logic        s_cyc_o,  s_cyc_o_z;
    logic        s_stb_o,  s_stb_o_z;
    logic [1:0]  grant_o,  grant_o_z;
    logic        timeout_o, timeout_o_z;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // Same stimulus, watchdog disabled
    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(0)) u_dut_nowd (
        .clk(clk), .reset_n(reset_n),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o_z), .m_ack_o(m_ack_o_z), .m_err_o(m_err_o_z),
        .s_adr_o(s_adr_o_z), .s_dat_o(s_dat_o_z), .s_sel_o(s_sel_o_z), .s_we_o(s_we_o_z),
        .s_cyc_o(s_cyc_o_z), .s_stb_o(s_stb_o_z),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o_z), .timeout_o(timeout_o_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
        m_cyc_i = '0; m_stb_i = '0;
        s_dat_i = 32'hA5A5_0001; s_ack_i = 1'b0; s_err_i = 1'b0;
        #3;
        n_tests++;
        if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, timeout_o, s_adr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: grant=%b cyc=%b stb=%b we=%b ack=%b err=%b to=%b adr=%h, expected all 0",
                     grant_o, s_cyc_o, s_stb_o, s_we_o, m_ack_o, m_err_o, timeout_o, s_adr_o);
        end
        n_tests++;
        if (m_dat_o !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL reset_dat_follow: got %h expected %h", m_dat_o, 32'hA5A5_0001);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        step();
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i = {32'h0, 32'h0000_0010};
        #1;
        n_tests++;
        if (grant_o !== 2'b00) begin
            n_fail++; $display("FAIL single_latency: grant got %b expected 00", grant_o);
        end
        step();
        #1;
        n_tests++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL single_grant: grant got %b expected 01", grant_o);
        end
        n_tests++;
        if ({s_cyc_o, s_stb_o, s_adr_o} !== {1'b1, 1'b1, 32'h10}) begin
            n_fail++; $display("FAIL single_slave_bus: cyc=%b stb=%b adr=%h expected 1 1 00000010",
                               s_cyc_o, s_stb_o, s_adr_o);
        end
        step();
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if ({m_ack_o, m_err_o} !== 4'b0100) begin
            n_fail++; $display("FAIL single_ack: ack=%b err=%b expected 01 00", m_ack_o, m_err_o);
        end
        n_tests++;
        if (m_dat_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", m_dat_o);
        end
        step();
        s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step();
        #1;
        n_tests++;
        if (grant_o !== 2'b00) begin
            n_fail++; $display("FAIL single_release: grant got %b expected 00", grant_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step();
        m_cyc_i = 2'b11; m_stb_i = 2'b11; m_adr_i = {32'h200, 32'h100};
        step();
        #1;
        n_tests++;
        if ({grant_o, s_adr_o} !== {2'b01, 32'h100}) begin
            n_fail++; $display("FAIL tie_first: grant=%b adr=%h expected 01 00000100", grant_o, s_adr_o);
        end
        s_ack_i = 1'b1;
        #1;
        n_tests++;
        if (m_ack_o !== 2'b01) begin
            n_fail++; $display("FAIL tie_ack0: ack got %b expected 01", m_ack_o);
        end
        step();
        s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10;
        step();
        #1;
        n_tests++;
        if ({grant_o, s_adr_o} !== {2'b10, 32'h200}) begin
            n_fail++; $display("FAIL direct_handover: grant=%b adr=%h expected 10 00000200", grant_o, s_adr_o);
        end
        s_ack_i = 1'b1;
        #1;
        n_tests++;
        if (m_ack_o !== 2'b10) begin
            n_fail++; $display("FAIL tie_ack1: ack got %b expected 10", m_ack_o);
        end
        step();
        s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step();
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        step();
        #1;
        n_tests++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL second_tie: grant got %b expected 01", grant_o);
        end
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step();
        step();
    endtask

    task automatic test_lock();
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_adr_i = {32'h300, 32'h0};
        step();
        #1;
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        for (int b = 0; b < 3; b++) begin
            s_ack_i = 1'b1;
            #1;
            n_tests++;
            if ({grant_o, m_ack_o} !== 4'b1010) begin
                n_fail++; $display("FAIL lock_beat%0d: grant=%b ack=%b expected 10 10", b, grant_o, m_ack_o);
            end
            step();
            s_ack_i = 1'b0;
            step();
        end
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        #1;
        n_tests++;
        if (grant_o !== 2'b10) begin
            n_fail++; $display("FAIL lock_drop_cycle: grant got %b expected 10", grant_o);
        end
        step();
        #1;
        n_tests++;
        if ({grant_o, s_adr_o} !== {2'b01, 32'h0}) begin
            n_fail++; $display("FAIL lock_release: grant=%b adr=%h expected 01 00000000", grant_o, s_adr_o);
        end
        s_ack_i = 1'b1;
        #1;
        n_tests++;
        if (m_ack_o !== 2'b01) begin
            n_fail++; $display("FAIL lock_ack0: ack got %b expected 01", m_ack_o);
        end
        step();
        s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step();
    endtask

    task automatic test_watchdog();
        step();
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i = {32'h0, 32'h40};
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if ({timeout_o, m_err_o, s_stb_o} !== 4'b0001) begin
                n_fail++; $display("FAIL wd_wait%0d: to=%b err=%b stb=%b expected 0 00 1",
                                   i, timeout_o, m_err_o, s_stb_o);
            end
            step();
        end
        #1;
        n_tests++;
        if ({timeout_o, m_err_o, s_stb_o, grant_o} !== 6'b101001) begin
            n_fail++; $display("FAIL wd_expire: to=%b err=%b stb=%b grant=%b expected 1 01 0 01",
                               timeout_o, m_err_o, s_stb_o, grant_o);
        end
        n_tests++;
        if ({timeout_o_z, m_err_o_z, s_stb_o_z} !== 4'b0001) begin
            n_fail++; $display("FAIL nowd_no_expire: to=%b err=%b stb=%b expected 0 00 1",
                               timeout_o_z, m_err_o_z, s_stb_o_z);
        end
        step();
        #1;
        n_tests++;
        if ({timeout_o, m_err_o, s_stb_o} !== 4'b0001) begin
            n_fail++; $display("FAIL wd_one_cycle: to=%b err=%b stb=%b expected 0 00 1",
                               timeout_o, m_err_o, s_stb_o);
        end
        m_stb_i = 2'b00;
        step();
        m_stb_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (timeout_o !== 1'b0) begin
                n_fail++; $display("FAIL wd_restart_wait%0d: to got %b expected 0", i, timeout_o);
            end
            step();
        end
        #1;
        n_tests++;
        if ({timeout_o, m_err_o} !== 3'b101) begin
            n_fail++; $display("FAIL wd_restart_expire: to=%b err=%b expected 1 01", timeout_o, m_err_o);
        end
        step();
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step();
    endtask

    task automatic test_ack_vs_expire();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        step();
        for (int i = 0; i < 4; i++) step();
        #1;
        n_tests++;
        if (timeout_o !== 1'b1) begin
            n_fail++; $display("FAIL race_at_limit: to got %b expected 1", timeout_o);
        end
        s_ack_i = 1'b1;
        #1;
        n_tests++;
        if ({m_ack_o, m_err_o, timeout_o, s_stb_o} !== 6'b010001) begin
            n_fail++; $display("FAIL race_ack_wins: ack=%b err=%b to=%b stb=%b expected 01 00 0 1",
                               m_ack_o, m_err_o, timeout_o, s_stb_o);
        end
        step();
        s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_adr_i = {32'h500, 32'h0};
        step();
        #1;
        n_tests++;
        if (grant_o !== 2'b10) begin
            n_fail++; $display("FAIL mid_pre_grant: grant got %b expected 10", grant_o);
        end
        reset_n = 1'b0; s_ack_i = 1'b1;
        #1;
        n_tests++;
        if ({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, s_adr_o} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outs: grant=%b cyc=%b stb=%b ack=%b err=%b adr=%h expected all 0",
                               grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, s_adr_o);
        end
        s_ack_i = 1'b0; m_cyc_i = 2'b11; m_stb_i = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        #1;
        n_tests++;
        if (grant_o !== 2'b01) begin
            n_fail++; $display("FAIL post_reset_tie: grant got %b expected 01", grant_o);
        end
        m_cyc_i = 2'b00; m_stb_i = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lock();
        test_watchdog();
        test_ack_vs_expire();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
